// File: rtl/sram_banked_top.sv
// ---------------------------------------------------------------------------
// sram_banked_top
//   Single-port synchronous SRAM of DEPTH x WIDTH words. The storage is split
//   into NUM_BANKS equal flop-based banks. The upper address bits select the
//   bank and the lower bits select the word within that bank. Reads have a
//   registered path with one cycle of latency. A write takes priority over a
//   read in the same cycle.
//
// Ports (sram_banked_top)
//   clk      in   1              single clock, rising edge
//   rst      in   1              synchronous reset, active-high
//   wren     in   1              write enable
//   rden     in   1              read enable (ignored while wren=1)
//   addr     in   $clog2(DEPTH)  word address: MSBs = bank, LSBs = word
//   wr_data  in   WIDTH          write data
//   rd_data  out  WIDTH          read data, valid the cycle after a read
//
// Ports (sram_bank)
//   clk, rst               as above
//   wr_en, rd_en           per-bank enables (mutually exclusive)
//   addr                   word index within the bank
//   wr_data                write data
//   rd_data                registered read data of this bank
// ---------------------------------------------------------------------------

module sram_bank #(
    parameter int WIDTH      = 16,
    parameter int BANK_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [$clog2(BANK_DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]              wr_data,
    output logic [WIDTH-1:0]              rd_data
);

    logic [WIDTH-1:0] mem_q [BANK_DEPTH];
    logic [WIDTH-1:0] mem_d [BANK_DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_en) begin
            mem_d[addr] = wr_data;
        end
        if (rd_en) begin
            rd_data_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is built from flops, so it can be cleared by reset; a real SRAM macro could not be cleared this way.
            for (int i = 0; i < BANK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every flop samples values from before the edge.
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

module sram_banked_top #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 1024,
    parameter int NUM_BANKS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wren,
    input  logic                     rden,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW         = $clog2(DEPTH);
    localparam int BW         = $clog2(NUM_BANKS);
    localparam int WW         = AW - BW;
    localparam int BANK_DEPTH = DEPTH / NUM_BANKS;

    logic [BW-1:0]        bank_idx;
    logic [WW-1:0]        word_idx;
    logic [NUM_BANKS-1:0] bank_sel;
    logic                 rd_go;
    logic [BW-1:0]        bank_sel_q;
    logic [BW-1:0]        bank_sel_d;
    logic [WIDTH-1:0]     bank_rd_data [NUM_BANKS];

    assign bank_idx = addr[AW-1 -: BW];
    assign word_idx = addr[WW-1:0];

    // A write wins a collision: no read happens and rd_data holds.
    assign rd_go = rden & ~wren;

    always_comb begin
        bank_sel           = '0;
        bank_sel[bank_idx] = 1'b1;
    end

    // The output mux follows the bank of the most recent read, so rd_data
    // holds while other banks are written or while idle.
    always_comb begin
        bank_sel_d = bank_sel_q;
        if (rd_go) begin
            bank_sel_d = bank_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q <= '0;
        end else begin
            bank_sel_q <= bank_sel_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank #(
            .WIDTH      (WIDTH),
            .BANK_DEPTH (BANK_DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wren & bank_sel[b]),
            .rd_en   (rd_go & bank_sel[b]),
            .addr    (word_idx),
            .wr_data (wr_data),
            .rd_data (bank_rd_data[b])
        );
    end

    assign rd_data = bank_rd_data[bank_sel_q];

endmodule

// File: tb/tb_sram_banked_top.sv
// ---------------------------------------------------------------------------
// tb_sram_banked_top
//   Scoreboard bench for sram_banked_top (default parameters). The stimulus
//   process pushes the hand-computed rd_data expected after an edge. A
//   monitor process pops the value and compares it to rd_data shortly after
//   that edge.
// ---------------------------------------------------------------------------

module tb_sram_banked_top;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 1024;
    localparam int NUM_BANKS = 4;
    localparam int AW        = $clog2(DEPTH);

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             wren;
    logic             rden;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

    logic             chk_req;
    exp_t             sb_q [$];
    int               n_checks;
    int               n_pass;
    bit               stim_done;

    sram_banked_top #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .NUM_BANKS (NUM_BANKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wren    (wren),
        .rden    (rden),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: rd_data=%h expected=%h", name, got, exp);
        end
    endtask

    // One clock of stimulus. Inputs change on the falling edge. When chk is
    // set, the expected rd_data after the next rising edge goes into the
    // scoreboard.
    task automatic op(input logic r, input logic w, input logic rd,
                      input int a, input logic [WIDTH-1:0] d,
                      input bit chk, input logic [WIDTH-1:0] exp,
                      input string name);
        exp_t e;
        @(negedge clk);
        rst     = r;
        wren    = w;
        rden    = rd;
        addr    = AW'(a);
        wr_data = d;
        chk_req = chk;
        if (chk) begin
            e.exp  = exp;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] d);
        op(1'b0, 1'b1, 1'b0, a, d, 1'b0, '0, "");
    endtask

    task automatic rd(input int a, input logic [WIDTH-1:0] exp, input string name);
        op(1'b0, 1'b0, 1'b1, a, '0, 1'b1, exp, name);
    endtask

    // Monitor: compares rd_data 1 time unit after each edge that the
    // stimulus marked for checking.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk_req) begin
                #1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_underflow: rd_data=%h expected=<none>", rd_data);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, rd_data, e.exp);
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        stim_done = 1'b0;
        rst       = 1'b1;
        wren      = 1'b0;
        rden      = 1'b0;
        addr      = '0;
        wr_data   = '0;
        chk_req   = 1'b0;

        // 1. Reset held for three cycles.
        op(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, '0, "");
        op(1'b1, 1'b0, 1'b0, 0, '0, 1'b0, '0, "");
        op(1'b1, 1'b0, 1'b0, 0, '0, 1'b1, 16'h0000, "reset_rd_data");
        rd(0, 16'h0000, "reset_read_addr0");

        // 2. Bank base words.
        wr(0,   16'h0010);
        wr(256, 16'h0011);
        wr(512, 16'h0012);
        wr(768, 16'h0013);
        rd(0,   16'h0010, "base_bank0");
        rd(256, 16'h0011, "base_bank1");
        rd(512, 16'h0012, "base_bank2");
        rd(768, 16'h0013, "base_bank3");

        // 3. Bank top words: no aliasing onto base words.
        wr(255,  16'h0020);
        wr(511,  16'h0021);
        wr(767,  16'h0022);
        wr(1023, 16'h0023);
        rd(1023, 16'h0023, "top_1023");
        rd(255,  16'h0020, "top_255");
        rd(511,  16'h0021, "top_511");
        rd(767,  16'h0022, "top_767");
        rd(0,    16'h0010, "base0_after_top");

        // 4. Mid-bank words; back-to-back reads on consecutive cycles.
        wr(120,  16'h0030);
        wr(420,  16'h0031);
        wr(620,  16'h0032);
        wr(1020, 16'h0033);
        rd(620,  16'h0032, "b2b_620");
        rd(420,  16'h0031, "b2b_420");
        rd(120,  16'h0030, "mid_120");
        rd(1020, 16'h0033, "mid_1020");

        // 5. A collision writes without reading. An idle cycle holds the
        //    output. A read right after a write sees the new data.
        op(1'b0, 1'b1, 1'b1, 5, 16'hAAAA, 1'b1, 16'h0033, "collision_hold");
        rd(5, 16'hAAAA, "read_after_collision");
        op(1'b0, 1'b0, 1'b0, 300, 16'h1234, 1'b1, 16'hAAAA, "idle_hold");
        op(1'b0, 1'b1, 1'b0, 900, 16'h5A5A, 1'b1, 16'hAAAA, "write_other_bank_hold");
        rd(900, 16'h5A5A, "raw_next_cycle");
        rd(5,   16'hAAAA, "idle_no_mem_change");

        // 6. Reset in the middle of a write burst. Reset wins over the write
        //    issued in the same cycle.
        wr(10,  16'h0055);
        wr(300, 16'h0056);
        op(1'b1, 1'b1, 1'b0, 400, 16'h0077, 1'b1, 16'h0000, "reset_mid_rd_data");
        wr(11,  16'h0058);
        rd(10,   16'h0000, "post_reset_10");
        rd(300,  16'h0000, "post_reset_300");
        rd(400,  16'h0000, "post_reset_400");
        rd(5,    16'h0000, "post_reset_5");
        rd(1023, 16'h0000, "post_reset_1023");
        rd(620,  16'h0000, "post_reset_620");
        rd(11,   16'h0058, "post_reset_write_11");

        op(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, '0, "");
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety timeout so the bench always terminates.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus_done=0 expected=1");
            $display("%0d/%0d checks passed", n_pass, n_checks + 1);
            $fatal(1, "timeout");
        end
    end

endmodule
